// File: rtl/ram_dma.sv
// ram_dma: block copy / block fill engine on a shared single-port synchronous RAM.
// Copy moves one word per READ -> CAPT -> WRITE round; fill writes one word per
// granted cycle. The RAM port is only used in cycles where mem_gnt is high.
module ram_dma #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  mode,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [ADDR_WIDTH-1:0] length,
    input  logic [DATA_WIDTH-1:0] fill_value,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    input  logic                  mem_gnt,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [2:0] {IDLE, READ, CAPT, WRITE, FIN} state_t;

    state_t                state, state_nxt;
    logic                  mode_r;
    logic [ADDR_WIDTH-1:0] src_ptr, dst_ptr, count;
    logic [DATA_WIDTH-1:0] fill_r, hold;
    logic                  accept, capture, wr_fire;

    // State register, operand latch, pointer/count advance and read-data hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            mode_r  <= 1'b0;
            src_ptr <= '0;
            dst_ptr <= '0;
            count   <= '0;
            fill_r  <= '0;
            hold    <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                mode_r  <= mode;
                src_ptr <= src_addr;
                dst_ptr <= dst_addr;
                count   <= length;
                fill_r  <= fill_value;
            end
            // The RAM output register may be reused by other masters later,
            // so the word is copied out in the cycle right after the read.
            if (capture) hold <= mem_rdata;
            if (wr_fire) begin
                dst_ptr <= dst_ptr + ADDR_WIDTH'(1);
                if (!mode_r) src_ptr <= src_ptr + ADDR_WIDTH'(1);
                count <= count - ADDR_WIDTH'(1);
            end
        end
    end

    // Next-state and bus decode; abort overrides grant and start everywhere.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        mem_cs    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        accept    = 1'b0;
        capture   = 1'b0;
        wr_fire   = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    accept = 1'b1;
                    if (length == '0) state_nxt = FIN;
                    else if (mode)    state_nxt = WRITE;
                    else              state_nxt = READ;
                end
            end
            READ: begin
                busy     = 1'b1;
                mem_addr = src_ptr;
                if (abort) begin
                    state_nxt = IDLE;
                end else if (mem_gnt) begin
                    mem_cs    = 1'b1;
                    state_nxt = CAPT;
                end
            end
            CAPT: begin
                busy      = 1'b1;
                capture   = 1'b1;
                state_nxt = abort ? IDLE : WRITE;
            end
            WRITE: begin
                busy      = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = dst_ptr;
                mem_wdata = mode_r ? fill_r : hold;
                if (abort) begin
                    state_nxt = IDLE;
                end else if (mem_gnt) begin
                    mem_cs  = 1'b1;
                    wr_fire = 1'b1;
                    if (count == ADDR_WIDTH'(1)) state_nxt = FIN;
                    else if (mode_r)             state_nxt = WRITE;
                    else                         state_nxt = READ;
                end
            end
            FIN: begin
                done      = !abort;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // No strobe may leave the block while reset is being applied.
        if (rst) mem_cs = 1'b0;
    end

endmodule

// File: tb/tb_ram_dma.sv
// tb_ram_dma: directed and randomized checks of ram_dma against a word-level
// memory model (fill = constant per word, copy = ascending word-by-word move).
module tb_ram_dma;
    localparam int AW = 16;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst, start, mode, abort, mem_gnt;
    logic [AW-1:0] src_addr, dst_addr, length;
    logic [DW-1:0] fill_value;
    logic          busy, done, mem_cs, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    // environment: RAM, preload port, second master
    logic          clr, tb_we, om_cs;
    logic [AW-1:0] tb_waddr, om_addr;
    logic [DW-1:0] tb_wdata;
    logic [DW-1:0] mem   [0:65535];
    logic [DW-1:0] model [0:65535];

    int checks = 0;
    int errors = 0;
    int first_bad;
    int unsigned cyc = 0, acc_cyc;
    int wr_cnt = 0, cs_cnt = 0, done_cnt = 0, busy_cnt = 0;
    int unsigned done_cyc = 0;
    logic [AW-1:0] wr_addr_q [$];
    int unsigned   wr_cyc_q  [$];

    ram_dma #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
        .fill_value(fill_value), .abort(abort), .busy(busy), .done(done),
        .mem_gnt(mem_gnt), .mem_cs(mem_cs), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Single-port synchronous RAM with registered read data.
    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 65536; i++) mem[i] <= '0;
            mem_rdata <= '0;
        end else begin
            if (tb_we) mem[tb_waddr] <= tb_wdata;
            if (mem_cs && mem_we)  mem[mem_addr] <= mem_wdata;
            else if (mem_cs)       mem_rdata <= mem[mem_addr];
            else if (om_cs)        mem_rdata <= mem[om_addr];
        end
    end

    // Bus monitor: logs every committed write and counts strobes, done, busy.
    always @(posedge clk) begin
        if (mem_cs && mem_we) begin
            wr_addr_q.push_back(mem_addr);
            wr_cyc_q.push_back(cyc);
            wr_cnt++;
        end
        if (mem_cs) cs_cnt++;
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (busy) busy_cnt++;
        cyc++;
    end

    function automatic int mem_diffs();
        int bad = 0;
        first_bad = 0;
        for (int i = 0; i < 65536; i++)
            if (mem[i] !== model[i]) begin
                if (bad == 0) first_bad = i;
                bad++;
            end
        return bad;
    endfunction

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        tb_we = 1'b1; tb_waddr = a; tb_wdata = d;
        @(negedge clk);
        tb_we = 1'b0;
        model[a] = d;
    endtask

    task automatic model_fill(input logic [AW-1:0] d, input int n, input logic [DW-1:0] v);
        for (int i = 0; i < n; i++) model[AW'(d + AW'(i))] = v;
    endtask

    task automatic model_copy(input logic [AW-1:0] s, input logic [AW-1:0] d, input int n);
        for (int i = 0; i < n; i++) model[AW'(d + AW'(i))] = model[AW'(s + AW'(i))];
    endtask

    // Present a one-cycle start; operands are scrambled afterwards so only the latched copy counts.
    task automatic do_start(input logic m, input logic [AW-1:0] s, input logic [AW-1:0] d,
                            input logic [AW-1:0] l, input logic [DW-1:0] f);
        mode = m; src_addr = s; dst_addr = d; length = l; fill_value = f;
        start = 1'b1;
        acc_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
        mode = 1'($urandom); src_addr = AW'($urandom); dst_addr = AW'($urandom);
        length = AW'($urandom); fill_value = DW'($urandom);
    endtask

    task automatic wait_idle(input int budget, input string name, input bit rand_gnt);
        int n = 0;
        while ((busy || done) && n < budget) begin
            if (rand_gnt) mem_gnt = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            n++;
        end
        mem_gnt = 1'b1;
        if (busy || done) begin
            checks++; errors++;
            $display("FAIL %s timeout: busy=%0b done=%0b after %0d cycles", name, busy, done, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; mode = 1'b1; length = 16'd5; dst_addr = 16'h0040;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0)      begin errors++; $display("FAIL reset_done got %b exp 0", done); end
        checks++; if (mem_cs !== 1'b0)    begin errors++; $display("FAIL reset_cs got %b exp 0", mem_cs); end
        checks++; if (mem_we !== 1'b0)    begin errors++; $display("FAIL reset_we got %b exp 0", mem_we); end
        checks++; if (mem_addr !== '0)    begin errors++; $display("FAIL reset_addr got %h exp 0", mem_addr); end
        checks++; if (mem_wdata !== '0)   begin errors++; $display("FAIL reset_wdata got %h exp 0", mem_wdata); end
        start = 1'b0; rst = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_no_latch busy got %b exp 0", busy); end
    endtask

    task automatic test_fill();
        int wb = wr_addr_q.size();
        int db = done_cnt;
        mem_gnt = 1'b1;
        do_start(1'b1, 16'h0777, 16'h1000, 16'd4, 8'hA5);
        model_fill(16'h1000, 4, 8'hA5);
        wait_idle(50, "fill", 1'b0);
        checks++; if (wr_addr_q.size() - wb !== 4) begin errors++; $display("FAIL fill_count got %0d exp 4", wr_addr_q.size() - wb); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (wb + i >= wr_addr_q.size()) begin
                errors++; $display("FAIL fill_write%0d missing", i);
            end else if (wr_addr_q[wb+i] !== AW'(16'h1000 + i) || wr_cyc_q[wb+i] !== acc_cyc + 1 + i) begin
                errors++; $display("FAIL fill_write%0d got addr %h cyc %0d exp addr %h cyc %0d", i,
                                   wr_addr_q[wb+i], wr_cyc_q[wb+i] - acc_cyc, 16'h1000 + i, 1 + i);
            end
        end
        checks++; if (done_cnt - db !== 1)          begin errors++; $display("FAIL fill_done_count got %0d exp 1", done_cnt - db); end
        checks++; if (done_cyc !== acc_cyc + 5)     begin errors++; $display("FAIL fill_done_time got %0d exp 5", done_cyc - acc_cyc); end
        checks++; if (mem_diffs() !== 0)            begin errors++; $display("FAIL fill_mem at %h got %h exp %h", first_bad, mem[first_bad], model[first_bad]); end
    endtask

    task automatic test_copy();
        int bb, db, wc;
        preload(16'h0200, 8'h11); preload(16'h0201, 8'h22); preload(16'h0202, 8'h33);
        bb = busy_cnt; db = done_cnt; wc = wr_cnt;
        mem_gnt = 1'b1;
        do_start(1'b0, 16'h0200, 16'h3000, 16'd3, 8'hEE);
        model_copy(16'h0200, 16'h3000, 3);
        wait_idle(60, "copy", 1'b0);
        checks++; if (busy_cnt - bb !== 9)       begin errors++; $display("FAIL copy_active got %0d exp 9", busy_cnt - bb); end
        checks++; if (done_cnt - db !== 1)       begin errors++; $display("FAIL copy_done_count got %0d exp 1", done_cnt - db); end
        checks++; if (done_cyc !== acc_cyc + 10) begin errors++; $display("FAIL copy_done_time got %0d exp 10", done_cyc - acc_cyc); end
        checks++; if (wr_cnt - wc !== 3)         begin errors++; $display("FAIL copy_writes got %0d exp 3", wr_cnt - wc); end
        checks++; if (mem_diffs() !== 0)         begin errors++; $display("FAIL copy_mem at %h got %h exp %h", first_bad, mem[first_bad], model[first_bad]); end
    endtask

    task automatic test_grant_stall();
        int n = 0;
        preload(16'h0400, 8'h5A); preload(16'h0401, 8'hC3); preload(16'h0000, 8'h77);
        mem_gnt = 1'b1;
        do_start(1'b0, 16'h0400, 16'h3100, 16'd2, 8'h00);
        model_copy(16'h0400, 16'h3100, 2);
        while (!(busy && mem_we) && n < 20) begin @(negedge clk); n++; end
        if (!(busy && mem_we)) begin
            checks++; errors++; $display("FAIL stall_reach_write timeout after %0d cycles", n);
        end
        mem_gnt = 1'b0; om_cs = 1'b1; om_addr = 16'h0000;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (mem_cs !== 1'b0) begin errors++; $display("FAIL stall_cs%0d got %b exp 0", i, mem_cs); end
            @(negedge clk);
        end
        om_cs = 1'b0; mem_gnt = 1'b1;
        wait_idle(60, "stall", 1'b0);
        checks++; if (mem_diffs() !== 0) begin errors++; $display("FAIL stall_mem at %h got %h exp %h", first_bad, mem[first_bad], model[first_bad]); end
    endtask

    task automatic test_wrap_zero();
        int wb = wr_addr_q.size();
        int cb, bb, db;
        logic [DW-1:0] f = DW'($urandom);
        logic [AW-1:0] exp_a [3] = '{16'hFFFE, 16'hFFFF, 16'h0000};
        mem_gnt = 1'b1;
        do_start(1'b1, 16'h1234, 16'hFFFE, 16'd3, f);
        model_fill(16'hFFFE, 3, f);
        wait_idle(50, "wrap", 1'b0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (wb + i >= wr_addr_q.size()) begin
                errors++; $display("FAIL wrap_write%0d missing", i);
            end else if (wr_addr_q[wb+i] !== exp_a[i]) begin
                errors++; $display("FAIL wrap_write%0d got %h exp %h", i, wr_addr_q[wb+i], exp_a[i]);
            end
        end
        checks++; if (mem_diffs() !== 0) begin errors++; $display("FAIL wrap_mem at %h got %h exp %h", first_bad, mem[first_bad], model[first_bad]); end
        cb = cs_cnt; bb = busy_cnt; db = done_cnt;
        do_start(1'($urandom), AW'($urandom), AW'($urandom), 16'd0, DW'($urandom));
        wait_idle(20, "zero", 1'b0);
        checks++; if (cs_cnt - cb !== 0)         begin errors++; $display("FAIL zero_cs got %0d exp 0", cs_cnt - cb); end
        checks++; if (busy_cnt - bb !== 0)       begin errors++; $display("FAIL zero_busy got %0d exp 0", busy_cnt - bb); end
        checks++; if (done_cnt - db !== 1)       begin errors++; $display("FAIL zero_done_count got %0d exp 1", done_cnt - db); end
        checks++; if (done_cyc !== acc_cyc + 1)  begin errors++; $display("FAIL zero_done_time got %0d exp 1", done_cyc - acc_cyc); end
    endtask

    task automatic test_overlap();
        for (int i = 0; i < 4; i++) preload(AW'(16'h0700 + i), DW'(i + 1));
        mem_gnt = 1'b1;
        do_start(1'b0, 16'h0700, 16'h0701, 16'd4, 8'h00);
        model_copy(16'h0700, 16'h0701, 4);
        wait_idle(60, "overlap", 1'b0);
        checks++; if (mem[16'h0704] !== 8'h01) begin errors++; $display("FAIL overlap_tail got %h exp 01", mem[16'h0704]); end
        checks++; if (mem_diffs() !== 0) begin errors++; $display("FAIL overlap_mem at %h got %h exp %h", first_bad, mem[first_bad], model[first_bad]); end
    endtask

    task automatic test_abort();
        int wc = wr_cnt;
        int db = done_cnt;
        int cb;
        mem_gnt = 1'b1;
        do_start(1'b1, 16'h0000, 16'h5000, 16'd100, 8'h3C);
        repeat (9) @(negedge clk);
        abort = 1'b1;
        #1;
        checks++; if (mem_cs !== 1'b0) begin errors++; $display("FAIL abort_cs got %b exp 0", mem_cs); end
        @(negedge clk);
        abort = 1'b0;
        model_fill(16'h5000, 9, 8'h3C);
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL abort_busy got %b exp 0", busy); end
        checks++; if (wr_cnt - wc !== 9)   begin errors++; $display("FAIL abort_writes got %0d exp 9", wr_cnt - wc); end
        @(negedge clk);
        checks++; if (done_cnt - db !== 0) begin errors++; $display("FAIL abort_done got %0d exp 0", done_cnt - db); end
        checks++; if (mem_diffs() !== 0)   begin errors++; $display("FAIL abort_mem at %h got %h exp %h", first_bad, mem[first_bad], model[first_bad]); end
        // start together with abort in IDLE is discarded
        cb = cs_cnt;
        mode = 1'b1; dst_addr = 16'h5200; length = 16'd5; start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || cs_cnt - cb !== 0) begin errors++; $display("FAIL start_abort got busy=%b cs=%0d exp 0 0", busy, cs_cnt - cb); end
        db = done_cnt;
        do_start(1'b1, 16'h0000, 16'h5100, 16'd2, 8'h99);
        model_fill(16'h5100, 2, 8'h99);
        wait_idle(30, "after_abort", 1'b0);
        checks++; if (done_cnt - db !== 1) begin errors++; $display("FAIL after_abort_done got %0d exp 1", done_cnt - db); end
        checks++; if (mem_diffs() !== 0)   begin errors++; $display("FAIL after_abort_mem at %h got %h exp %h", first_bad, mem[first_bad], model[first_bad]); end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        int wc, db;
        preload(16'h0600, 8'hAB); preload(16'h0601, 8'hCD);
        wc = wr_cnt; db = done_cnt;
        mem_gnt = 1'b1;
        do_start(1'b0, 16'h0600, 16'h3200, 16'd2, 8'h00);
        while (!(busy && !mem_cs && !mem_we) && n < 20) begin @(negedge clk); n++; end
        if (!(busy && !mem_cs && !mem_we)) begin
            checks++; errors++; $display("FAIL rstmid_reach_capt timeout after %0d cycles", n);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || mem_cs !== 1'b0 || mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0) begin
            errors++; $display("FAIL rstmid_outputs got busy=%b done=%b cs=%b we=%b addr=%h wdata=%h exp all 0",
                               busy, done, mem_cs, mem_we, mem_addr, mem_wdata);
        end
        rst = 1'b0;
        repeat (6) @(negedge clk);
        checks++; if (wr_cnt - wc !== 0 || done_cnt - db !== 0) begin errors++; $display("FAIL rstmid_activity got writes=%0d done=%0d exp 0 0", wr_cnt - wc, done_cnt - db); end
        checks++; if (mem_diffs() !== 0) begin errors++; $display("FAIL rstmid_mem at %h got %h exp %h", first_bad, mem[first_bad], model[first_bad]); end
    endtask

    task automatic test_random();
        for (int t = 0; t < 25; t++) begin
            logic m = 1'($urandom);
            logic [AW-1:0] s = AW'($urandom);
            logic [AW-1:0] d = AW'($urandom);
            int l = $urandom_range(0, 10);
            logic [DW-1:0] f = DW'($urandom);
            int wc, db;
            if (!m) for (int i = 0; i < l; i++) preload(AW'(s + AW'(i)), DW'($urandom));
            wc = wr_cnt; db = done_cnt;
            mem_gnt = ($urandom_range(0, 3) != 0);
            do_start(m, s, d, AW'(l), f);
            if (m) model_fill(d, l, f); else model_copy(s, d, l);
            wait_idle(600, "random", 1'b1);
            checks++; if (done_cnt - db !== 1) begin errors++; $display("FAIL rand%0d_done got %0d exp 1", t, done_cnt - db); end
            checks++; if (wr_cnt - wc !== l)   begin errors++; $display("FAIL rand%0d_writes got %0d exp %0d", t, wr_cnt - wc, l); end
            checks++; if (mem_diffs() !== 0)   begin errors++; $display("FAIL rand%0d_mem at %h got %h exp %h", t, first_bad, mem[first_bad], model[first_bad]); end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mode = 1'b0; abort = 1'b0; mem_gnt = 1'b1;
        src_addr = '0; dst_addr = '0; length = '0; fill_value = '0;
        clr = 1'b1; tb_we = 1'b0; tb_waddr = '0; tb_wdata = '0; om_cs = 1'b0; om_addr = '0;
        for (int i = 0; i < 65536; i++) model[i] = '0;
        @(negedge clk);
        clr = 1'b0;
        test_reset();
        test_fill();
        test_copy();
        test_grant_stall();
        test_wrap_zero();
        test_overlap();
        test_abort();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
